// File: rtl/uart_tx_fifo.sv
// Byte-oriented UART transmitter (8N1, LSB first) fed by a small circular FIFO.
// The FIFO pops straight into the shift register, so back-to-back frames leave no idle gap on tx.
module uart_tx_fifo #(
    parameter int CLK_DIV = 100,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(CLK_DIV);

    localparam logic [TW-1:0]      T_LAST   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]      T_ONE    = TW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]         mem_q [DEPTH];

    state_t             state_q,   state_d;
    logic [TW-1:0]      timer_q,   timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q,   shift_d;
    logic               tx_q,      tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [FIFO_AW:0]   count_q,   count_d;
    logic               overflow_q, overflow_d;

    logic wr_acc;
    logic timer_done;
    logic pop;

    always_comb begin
        // A full FIFO refuses the write even when a pop frees a slot on the same edge.
        wr_acc     = wr_en && (count_q != CNT_FULL);
        timer_done = (timer_q == T_LAST);
        pop        = (count_q != '0) &&
                     ((state_q == IDLE) || ((state_q == STOP) && timer_done));

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale entries are never read because count gates every pop.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = (count_q == CNT_FULL);
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign overflow = overflow_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: exact frame timing, back-to-back frames, overflow,
// reset mid-frame and pointer wrap, with a mid-bit line receiver collecting emitted bytes.
module tb_uart_tx_fifo;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    logic [7:0] wbuf [16];
    logic [7:0] wrap_vals [10] = '{8'h5A, 8'hC3, 8'h00, 8'hFF, 8'h81,
                                   8'h7E, 8'h12, 8'h34, 8'h9B, 8'hE6};

    uart_tx_fifo #(
        .CLK_DIV (100),
        .FIFO_AW (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Writes wbuf[0..n-1] on consecutive edges; returns at the negedge after the last write edge.
    task automatic write_buf(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = wbuf[i];
        end
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        rx_q.delete();
    endtask

    // Entered at the negedge right after the start edge; leaves at the last stop-bit cycle.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        int   bi;
        int   c;
        logic e;
        for (int j = 1; j <= 1000; j++) begin
            if (j > 1) @(negedge clk);
            bi = (j - 1) / 100;
            c  = (j - 1) % 100;
            if (c == 0 || c == 99) begin
                if (bi == 0)      e = 1'b0;
                else if (bi == 9) e = 1'b1;
                else              e = b[bi-1];
                check($sformatf("%s_b%0d_c%0d", tag, bi, c), 32'(tx), 32'(e));
            end
        end
    endtask

    task automatic expect_rx(input string tag, input int n, input int first);
        check($sformatf("%s_count", tag), 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(wbuf[first + i]));
        end
    endtask

    // Line receiver: samples mid-bit, abandons any frame interrupted by reset.
    initial begin : line_mon
        logic [9:0] bits;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                aborted = 1'b0;
                bits    = '0;
                for (int j = 1; j <= 950; j++) begin
                    if (j > 1) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    if (j % 100 == 50) bits[j/100] = tx;
                end
                if (!aborted) begin
                    check("mon_start", 32'(bits[0]), 32'd0);
                    check("mon_stop", 32'(bits[9]), 32'd1);
                    rx_q.push_back(bits[8:1]);
                    $display("rx byte 0x%02h at %0t", bits[8:1], $time);
                end
            end
        end
    end

    initial begin : main
        int quiet;

        // Reset state
        tick(2);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("idle_tx", 32'(tx), 32'd1);

        // Single byte: written at edge k, start bit from k+1, idle again at k+1001
        wbuf[0] = 8'hA5;
        write_buf(1);
        check("single_k_tx", 32'(tx), 32'd1);
        check("single_k_busy", 32'(busy), 32'd1);
        tick(1);
        expect_frame(8'hA5, "single");
        check("single_k1000_busy", 32'(busy), 32'd1);
        tick(1);
        check("single_k1001_busy", 32'(busy), 32'd0);
        check("single_k1001_tx", 32'(tx), 32'd1);
        tick(5);
        expect_rx("single_rx", 1, 0);
        rx_q.delete();

        // Back-to-back frames with no idle cycle between them
        wbuf[0] = 8'h01;
        wbuf[1] = 8'h80;
        write_buf(2);
        expect_frame(8'h01, "b2b0");
        tick(1);
        expect_frame(8'h80, "b2b1");
        tick(1);
        check("b2b_end_busy", 32'(busy), 32'd0);
        tick(5);
        expect_rx("b2b_rx", 2, 0);
        rx_q.delete();

        // Overflow: 0x15 is dropped once four bytes are queued behind 0x10
        for (int i = 0; i < 6; i++) wbuf[i] = 8'h10 + 8'(i);
        write_buf(6);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        tick(5000);
        check("ovf_end_busy", 32'(busy), 32'd0);
        check("ovf_end_full", 32'(full), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        expect_rx("ovf_rx", 5, 0);

        // Write landing on the STOP-end pop while full is dropped
        do_reset();
        check("wpop_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) wbuf[i] = 8'h20 + 8'(i);
        write_buf(5);
        check("wpop_full", 32'(full), 32'd1);
        tick(996);
        check("wpop_pre_full", 32'(full), 32'd1);
        check("wpop_pre_tx", 32'(tx), 32'd1);
        check("wpop_pre_ovf", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'h00;
        check("wpop_ovf", 32'(overflow), 32'd1);
        check("wpop_full_after", 32'(full), 32'd0);
        check("wpop_next_start", 32'(tx), 32'd0);
        tick(4100);
        check("wpop_end_busy", 32'(busy), 32'd0);
        expect_rx("wpop_rx", 5, 0);

        // Reset during data bit 3 of 0x3C with two bytes queued
        do_reset();
        wbuf[0] = 8'h3C;
        wbuf[1] = 8'hAA;
        wbuf[2] = 8'h55;
        write_buf(3);
        tick(448);
        check("rmid_pre_tx", 32'(tx), 32'd1);
        check("rmid_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_tx", 32'(tx), 32'd1);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_full", 32'(full), 32'd0);
        check("rmid_ovf", 32'(overflow), 32'd0);
        tick(2);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx === 1'b1 && busy === 1'b0) quiet++;
        end
        check("rmid_quiet_cycles", 32'(quiet), 32'd2000);
        check("rmid_rx_count", 32'(rx_q.size()), 32'd0);

        // Pointer wrap: ten bytes, one per frame time, emitted in order
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            wbuf[0] = wrap_vals[i];
            write_buf(1);
            tick(998);
        end
        tick(1100);
        check("wrap_busy", 32'(busy), 32'd0);
        check("wrap_ovf", 32'(overflow), 32'd0);
        check("wrap_count", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size())
                check($sformatf("wrap_byte%0d", i), 32'(rx_q[i]), 32'(wrap_vals[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
